// File: rtl/video_timing_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : video_timing_gen                                           |
// | Description : Free-running raster timing generator. Produces the pixel   |
// |               counters CounterX/CounterY plus registered hsync, vsync,   |
// |               data enable, a start-of-frame tick and a frame counter.    |
// |               One pixel per clk.                                         |
// |                                                                          |
// | Ports       : clk         in   pixel clock, rising edge                  |
// |               reset_n     in   asynchronous active-low reset             |
// |               CounterX    out  [11:0] horizontal position 0..hTotal-1    |
// |               CounterY    out  [11:0] vertical position 0..vTotal-1      |
// |               hsync       out  horizontal sync (polarity SyncPolarity)   |
// |               vsync       out  vertical sync (polarity SyncPolarity)     |
// |               de          out  data enable, high on active pixels        |
// |               frame_tick  out  one-clock pulse at start of frame         |
// |               frame_count out  [7:0] frames completed, wraps at 256      |
// |                                                                          |
// | Build macro : VTG_EXTRA_PIPE_EN - adds one more register stage on        |
// |               hsync/vsync/de/frame_tick (2 clocks lag instead of 1).     |
// |                                                                          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module video_timing_gen #(
  parameter int hDrawArea    = 640,
  parameter int hFrontPorch  = 16,
  parameter int hSyncLen     = 96,
  parameter int hBackPorch   = 48,
  parameter int vDrawArea    = 480,
  parameter int vFrontPorch  = 10,
  parameter int vSyncLen     = 2,
  parameter int vBackPorch   = 33,
  parameter int SyncPolarity = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [11:0] CounterX,
  output logic [11:0] CounterY,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        frame_tick,
  output logic [7:0]  frame_count
);

  localparam int H_TOTAL = hDrawArea + hFrontPorch + hSyncLen + hBackPorch;
  localparam int V_TOTAL = vDrawArea + vFrontPorch + vSyncLen + vBackPorch;

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);

  // Window bounds are 13 bits wide so an end bound of exactly 4096 still fits.
  localparam logic [12:0] H_ACT_END  = 13'(hDrawArea);
  localparam logic [12:0] HS_START   = 13'(hDrawArea + hFrontPorch);
  localparam logic [12:0] HS_END     = 13'(hDrawArea + hFrontPorch + hSyncLen);
  localparam logic [12:0] V_ACT_END  = 13'(vDrawArea);
  localparam logic [12:0] VS_START   = 13'(vDrawArea + vFrontPorch);
  localparam logic [12:0] VS_END     = 13'(vDrawArea + vFrontPorch + vSyncLen);

  // Sync level outside the sync window (1 for active-low panels).
  localparam logic SYNC_IDLE = (SyncPolarity == 0);

  logic [11:0] cnt_x_q, cnt_x_d;
  logic [11:0] cnt_y_q, cnt_y_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;

  logic        hs_raw, vs_raw, de_raw, tick_raw;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        de_q, de_d;
  logic        tick_q, tick_d;

  // Counter next-state: X wraps every line, Y steps on the X wrap, and the
  // frame counter steps on the edge where both wrap to (0,0).
  always_comb begin
    cnt_x_d     = cnt_x_q + 12'd1;
    cnt_y_d     = cnt_y_q;
    frame_cnt_d = frame_cnt_q;
    if (cnt_x_q == H_LAST) begin
      cnt_x_d = 12'd0;
      if (cnt_y_q == V_LAST) begin
        cnt_y_d     = 12'd0;
        frame_cnt_d = frame_cnt_q + 8'd1;
      end else begin
        cnt_y_d = cnt_y_q + 12'd1;
      end
    end
  end

  // Decode from the current counter values; registered below so the outputs
  // align with RGB registered downstream from the same counters.
  always_comb begin
    hs_raw   = ({1'b0, cnt_x_q} >= HS_START) && ({1'b0, cnt_x_q} < HS_END);
    vs_raw   = ({1'b0, cnt_y_q} >= VS_START) && ({1'b0, cnt_y_q} < VS_END);
    de_raw   = ({1'b0, cnt_x_q} < H_ACT_END) && ({1'b0, cnt_y_q} < V_ACT_END);
    tick_raw = (cnt_x_q == 12'd0) && (cnt_y_q == 12'd0);
    hsync_d  = hs_raw ^ SYNC_IDLE;
    vsync_d  = vs_raw ^ SYNC_IDLE;
    de_d     = de_raw;
    tick_d   = tick_raw;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_x_q     <= 12'd0;
      cnt_y_q     <= 12'd0;
      frame_cnt_q <= 8'd0;
      hsync_q     <= SYNC_IDLE;
      vsync_q     <= SYNC_IDLE;
      de_q        <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      cnt_x_q     <= cnt_x_d;
      cnt_y_q     <= cnt_y_d;
      frame_cnt_q <= frame_cnt_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      de_q        <= de_d;
      tick_q      <= tick_d;
    end
  end

`ifdef VTG_EXTRA_PIPE_EN
  // Second stage for a downstream output stage that re-registers RGB.
  logic hsync_p2_q, vsync_p2_q, de_p2_q, tick_p2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hsync_p2_q <= SYNC_IDLE;
      vsync_p2_q <= SYNC_IDLE;
      de_p2_q    <= 1'b0;
      tick_p2_q  <= 1'b0;
    end else begin
      hsync_p2_q <= hsync_q;
      vsync_p2_q <= vsync_q;
      de_p2_q    <= de_q;
      tick_p2_q  <= tick_q;
    end
  end

  assign hsync      = hsync_p2_q;
  assign vsync      = vsync_p2_q;
  assign de         = de_p2_q;
  assign frame_tick = tick_p2_q;
`else
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign de         = de_q;
  assign frame_tick = tick_q;
`endif

  assign CounterX    = cnt_x_q;
  assign CounterY    = cnt_y_q;
  assign frame_count = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_video_timing_gen                                        |
// | Description : Self-checking bench for video_timing_gen. Instance d_ uses |
// |               default 800x525 timing; instance s_ uses a 16x10 raster    |
// |               with active-high syncs so frame wrap and frame_count       |
// |               rollover are reachable. Expected values derive from the    |
// |               number of clock edges since reset release.                 |
// |               Honours VTG_EXTRA_PIPE_EN (sync/DE/tick lag 2 instead of 1)|
// |                                                                          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_video_timing_gen;

`ifdef VTG_EXTRA_PIPE_EN
  localparam int LAG = 2;
`else
  localparam int LAG = 1;
`endif

  localparam int S_FRAME = 160;  // 16 x 10

  logic        clk = 1'b0;
  logic        reset_n;

  logic [11:0] d_cx, d_cy, s_cx, s_cy;
  logic        d_hs, d_vs, d_de, d_tick;
  logic        s_hs, s_vs, s_de, s_tick;
  logic [7:0]  d_fc, s_fc;

  int n_checks = 0;
  int n_pass   = 0;
  bit count_en = 1'b0;
  int s_de_cnt = 0, s_vs_cnt = 0, s_tick_cnt = 0;
  int d_de_cnt = 0, d_hs_cnt = 0;

  always #5 clk = ~clk;

  video_timing_gen u_dut_d (
    .clk        (clk),
    .reset_n    (reset_n),
    .CounterX   (d_cx),
    .CounterY   (d_cy),
    .hsync      (d_hs),
    .vsync      (d_vs),
    .de         (d_de),
    .frame_tick (d_tick),
    .frame_count(d_fc)
  );

  video_timing_gen #(
    .hDrawArea   (8),
    .hFrontPorch (2),
    .hSyncLen    (3),
    .hBackPorch  (3),
    .vDrawArea   (6),
    .vFrontPorch (1),
    .vSyncLen    (2),
    .vBackPorch  (1),
    .SyncPolarity(1)
  ) u_dut_s (
    .clk        (clk),
    .reset_n    (reset_n),
    .CounterX   (s_cx),
    .CounterY   (s_cy),
    .hsync      (s_hs),
    .vsync      (s_vs),
    .de         (s_de),
    .frame_tick (s_tick),
    .frame_count(s_fc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic check_reset(input string where);
    check({where, "_d_cx"},   32'(d_cx),   32'd0);
    check({where, "_d_cy"},   32'(d_cy),   32'd0);
    check({where, "_d_fc"},   32'(d_fc),   32'd0);
    check({where, "_d_hs"},   32'(d_hs),   32'd1);
    check({where, "_d_vs"},   32'(d_vs),   32'd1);
    check({where, "_d_de"},   32'(d_de),   32'd0);
    check({where, "_d_tick"}, 32'(d_tick), 32'd0);
    check({where, "_s_cx"},   32'(s_cx),   32'd0);
    check({where, "_s_cy"},   32'(s_cy),   32'd0);
    check({where, "_s_fc"},   32'(s_fc),   32'd0);
    check({where, "_s_hs"},   32'(s_hs),   32'd0);
    check({where, "_s_vs"},   32'(s_vs),   32'd0);
    check({where, "_s_de"},   32'(s_de),   32'd0);
    check({where, "_s_tick"}, 32'(s_tick), 32'd0);
  endtask

  // n = number of rising edges since reset release. Counters show the raster
  // position n; registered outputs show the decode of position n-LAG.
  task automatic check_step(input int n);
    int  p, x, y;
    bit  hs, vs, de_e, tk;
    check("d_cx", 32'(d_cx), 32'(n % 800));
    check("d_cy", 32'(d_cy), 32'((n / 800) % 525));
    check("d_fc", 32'(d_fc), 32'((n / 420000) % 256));
    check("s_cx", 32'(s_cx), 32'(n % 16));
    check("s_cy", 32'(s_cy), 32'((n / 16) % 10));
    check("s_fc", 32'(s_fc), 32'((n / S_FRAME) % 256));
    check("xz", 32'($isunknown({d_cx, d_cy, d_hs, d_vs, d_de, d_tick, d_fc,
                                s_cx, s_cy, s_hs, s_vs, s_de, s_tick, s_fc})), 32'd0);
    p = n - LAG;
    if (p < 0) begin
      check("d_hs_pipe", 32'(d_hs), 32'd1);
      check("d_de_pipe", 32'(d_de), 32'd0);
      check("s_vs_pipe", 32'(s_vs), 32'd0);
      check("s_tick_pipe", 32'(s_tick), 32'd0);
    end else begin
      x    = p % 800;
      y    = (p / 800) % 525;
      hs   = (x >= 656) && (x < 752);
      vs   = (y >= 490) && (y < 492);
      de_e = (x < 640) && (y < 480);
      tk   = (p % 420000) == 0;
      check("d_hsync", 32'(d_hs),   32'(!hs));
      check("d_vsync", 32'(d_vs),   32'(!vs));
      check("d_de",    32'(d_de),   32'(de_e));
      check("d_tick",  32'(d_tick), 32'(tk));
      x    = p % 16;
      y    = (p / 16) % 10;
      hs   = (x >= 10) && (x < 13);
      vs   = (y >= 7) && (y < 9);
      de_e = (x < 8) && (y < 6);
      tk   = (p % S_FRAME) == 0;
      check("s_hsync", 32'(s_hs),   32'(hs));
      check("s_vsync", 32'(s_vs),   32'(vs));
      check("s_de",    32'(s_de),   32'(de_e));
      check("s_tick",  32'(s_tick), 32'(tk));
      if (count_en && p < 256 * S_FRAME) begin
        s_de_cnt   += int'(s_de === 1'b1);
        s_vs_cnt   += int'(s_vs === 1'b1);
        s_tick_cnt += int'(s_tick === 1'b1);
      end
      if (count_en && p < 80000) begin
        d_de_cnt += int'(d_de === 1'b1);
        d_hs_cnt += int'(d_hs === 1'b0);
      end
    end
  endtask

  initial begin
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("rst0");

    reset_n  = 1'b1;
    count_en = 1'b1;
    // Runs to CounterX=300, CounterY=100 on the default raster.
    for (int n = 1; n <= 80300; n++) begin
      @(negedge clk);
      check_step(n);
    end

    // 256 short frames: 8x6 active, 2 sync lines of 16, one tick each.
    check("s_de_total",   32'(s_de_cnt),   32'(256 * 48));
    check("s_vs_total",   32'(s_vs_cnt),   32'(256 * 32));
    check("s_tick_total", 32'(s_tick_cnt), 32'd256);
    // First 100 default lines: 640 DE and 96 hsync clocks per line.
    check("d_de_total",   32'(d_de_cnt),   32'(100 * 640));
    check("d_hs_total",   32'(d_hs_cnt),   32'(100 * 96));
    check("mid_cx", 32'(d_cx), 32'd300);
    check("mid_cy", 32'(d_cy), 32'd100);

    // Asynchronous reset between edges must clear outputs before next edge.
    count_en = 1'b0;
    #2 reset_n = 1'b0;
    #1 check_reset("async");
    repeat (2) @(negedge clk);
    check_reset("hold");
    reset_n = 1'b1;
    for (int n = 1; n <= 2000; n++) begin
      @(negedge clk);
      check_step(n);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
